mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the shared data RAM.
REQ-002 SHALL have parameter STARVE_MAX, default 4, core-won cycles a pending DMA request tolerates before it is forced.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports core_req input 1, core_addr input ADDR_W, core_wdata input 32, core_wmask input 4: memory-stage access; wmask=0 means read.
REQ-006 SHALL have ports core_rdata output 32 (core read data) and core_stall output 1 (freeze pipeline this cycle).
REQ-007 SHALL have ports dma_valid input 1, dma_ready output 1, dma_we input 1, dma_addr input ADDR_W, dma_wdata input 32, dma_wmask input 4: second requester, valid/ready.
REQ-008 SHALL have ports dma_rvalid output 1 and dma_rdata output 32: DMA read return.
REQ-009 SHALL have ports ram_addr output ADDR_W, ram_wdata output 32, ram_wmask output 4, ram_rdata input 32: single-port RAM, synchronous read, 1-cycle latency.

Function
REQ-010 SHALL grant exactly one owner per cycle: CORE, DMA or NONE; the RAM port SHALL carry only the owner's address, data and mask; NONE drives wmask=0.
REQ-011 SHALL grant CORE when core_req=1 and no force condition holds (REQ-014).
REQ-012 SHALL grant DMA when dma_valid=1 and core_req=0; dma_ready=1 that cycle, combinationally; handshake = dma_valid & dma_ready.
REQ-013 SHALL present dma_wmask on ram_wmask only when dma_we=1; DMA reads drive wmask=0.
REQ-014 SHALL keep starve counter (width ceil(log2(STARVE_MAX+1))): +1 per cycle dma_valid=1 and dma_ready=0, saturating at STARVE_MAX; cleared on DMA handshake.
REQ-015 SHALL, when counter==STARVE_MAX and dma_valid=1 and core_req=1, grant DMA, assert dma_ready=1 and core_stall=1 in that same cycle.
REQ-016 SHALL otherwise hold core_stall=0; a stalled core re-presents the same request next cycle and wins it (counter just cleared).
REQ-017 SHALL register owner of the previous cycle (owner_q); core_rdata = ram_rdata when owner_q==CORE, else 0.
REQ-018 SHALL assert dma_rvalid for exactly one cycle, the cycle after a DMA read handshake, with dma_rdata = ram_rdata; dma_rdata = 0 when dma_rvalid=0.
REQ-019 SHALL produce no dma_rvalid for DMA writes.
REQ-020 SHALL sustain back-to-back DMA handshakes every cycle while core_req=0 (throughput 1/cycle, latency 1).
REQ-021 SHALL treat dma_valid dropped before handshake as withdrawal: counter cleared, no access.

Reset
REQ-022 SHALL, while resetn=0, force dma_ready=0, dma_rvalid=0, core_stall=0, ram_wmask=0, core_rdata=0, dma_rdata=0, owner_q=NONE, counter=0, asynchronously.
REQ-023 SHALL discard a DMA read return pending when reset asserts; no dma_rvalid after release for it.
REQ-024 SHALL allow first grant on the first rising edge with resetn=1.

Configuration
REQ-025 SHALL use macro ARB_STARVE_EN: defined -> REQ-014/015 active; undefined -> strict core priority, no counter, core_stall tied 0, DMA served only on core_req=0 cycles.

Verification
REQ-026 SHALL test: core_req=1 reads addr 0x010 holding 0xDEADBEEF, dma idle -> next cycle core_rdata=0xDEADBEEF, dma_ready=0.
REQ-027 SHALL test: core_req=0, DMA writes 0xCAFEF00D mask 4'b1111 at 0x020 then reads 0x020 -> dma_ready=1 both cycles, dma_rvalid=1 one cycle later with dma_rdata=0xCAFEF00D.
REQ-028 SHALL test (ARB_STARVE_EN, STARVE_MAX=4): core_req held 1, dma_valid=1 -> 4 cycles dma_ready=0, 5th cycle dma_ready=1 and core_stall=1, 6th cycle core granted, core_stall=0.
REQ-029 SHALL test (ARB_STARVE_EN undefined): same stimulus for 20 cycles -> dma_ready=0 and core_stall=0 throughout; core_req drop -> dma_ready=1 same cycle.
REQ-030 SHALL test: DMA read handshake at cycle N, resetn low at N+0.5 -> dma_rvalid=0 at N+1 and after release, counter=0.
REQ-031 SHALL test: dma_valid withdrawn at counter=3, re-asserted with core_req=1 -> force occurs only after 4 further cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the core memory stage and a DMA requester.
// Define ARB_STARVE_EN to enable the DMA starvation counter; otherwise the core has strict priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_wmask,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_wmask,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wmask,
    input  logic [31:0]       ram_rdata
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CORE = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    if (STARVE_MAX < 1) begin : g_cfg_err
        $error("mem_port_arbiter: STARVE_MAX must be at least 1");
    end

    logic [1:0] owner;
    logic [1:0] owner_q, owner_d;
    logic       rvalid_q, rvalid_d;
    logic       force_dma;
    logic       dma_hs;

`ifdef ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    always_comb force_dma = core_req & dma_valid & (starve_q == CNT_W'(STARVE_MAX));

    // Withdrawal and handshake both restart the wait.
    always_comb begin
        starve_d = starve_q;
        if (!dma_valid || dma_hs)
            starve_d = '0;
        else if (starve_q != CNT_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`else
    assign force_dma = 1'b0;
`endif

    // Reset forces NONE so the RAM sees no write and DMA sees no ready.
    always_comb begin
        owner = OWN_NONE;
        if (force_dma)      owner = OWN_DMA;
        else if (core_req)  owner = OWN_CORE;
        else if (dma_valid) owner = OWN_DMA;
        if (!resetn)        owner = OWN_NONE;
    end

    assign dma_ready  = (owner == OWN_DMA);
    assign dma_hs     = dma_valid & dma_ready;
    assign core_stall = force_dma & resetn;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        case (owner)
            OWN_CORE: begin
                ram_addr  = core_addr;
                ram_wdata = core_wdata;
                ram_wmask = core_wmask;
            end
            OWN_DMA: begin
                ram_addr  = dma_addr;
                ram_wdata = dma_wdata;
                ram_wmask = dma_we ? dma_wmask : 4'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d  = owner;
        rvalid_d = dma_hs & ~dma_we;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q  <= OWN_NONE;
            rvalid_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign core_rdata = (owner_q == OWN_CORE) ? ram_rdata : 32'h0;
    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rvalid_q ? ram_rdata : 32'h0;
endmodule
